// File: rtl/pokey_serout_ctrl_pkg.sv
// Shared definitions for the POKEY serial-output sequencer: state encoding,
// IRQ bit positions and frame-size defaults.
package pokey_serout_ctrl_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int STOP_BITS_DEF = 1;

    // Bit positions of the serial-output interrupt sources in IRQST/IRQEN
    localparam int IRQ_SEROC = 3;
    localparam int IRQ_SEROR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } state_e;

endpackage

// File: rtl/pokey_serout_ctrl_if.sv
// Bus between register decode / timer side and the serial-output sequencer.
interface pokey_serout_ctrl_if
    import pokey_serout_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic                 enp;
    logic                 bit_tick;
    logic                 serout_wr;
    logic [DATA_BITS-1:0] serout_data;
    logic                 force_break;
    logic                 sod;
    logic                 serout_need;
    logic                 xmit_done;
    logic                 busy;

    modport master (
        output enp, bit_tick, serout_wr, serout_data, force_break,
        input  sod, serout_need, xmit_done, busy
    );

    modport slave (
        input  enp, bit_tick, serout_wr, serout_data, force_break,
        output sod, serout_need, xmit_done, busy
    );

endinterface

// File: rtl/pokey_shift_chain.sv
// Chain of enp-gated set/shift cells; cell 0 is the bit about to go on the wire.
// Load replaces every cell with its Set value, Shift moves toward cell 0 filling from D.
module pokey_shift_chain
    import pokey_serout_ctrl_pkg::*;
#(
    parameter int N = DATA_BITS_DEF + STOP_BITS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enp_i,
    input  logic         shift_i,
    input  logic         load_i,
    input  logic [N-1:0] set_i,
    input  logic         d_i,
    output logic         q0_o
);

    logic [N-1:0] chain_q;
    logic [N-1:0] chain_d;

    // Next value of every cell: load has priority over shift
    always_comb begin
        chain_d = chain_q;
        if (load_i) begin
            chain_d = set_i;
        end else if (shift_i) begin
            chain_d = {d_i, chain_q[N-1:1]};
        end else begin
            chain_d = chain_q;
        end
    end

    // Cell storage, idles at mark (all ones)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else if (enp_i) begin
            chain_q <= chain_d;
        end
    end

    assign q0_o = chain_q[0];

endmodule

// File: rtl/pokey_serout_ctrl.sv
// POKEY serial-output sequencer: buffers the SEROUT byte and frames it as
// start bit, LSB-first data and stop bit(s), one bit per bit_tick.
module pokey_serout_ctrl
    import pokey_serout_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pokey_serout_ctrl_if.slave  bus
);

    localparam int N   = DATA_BITS + STOP_BITS;
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_e               state_q, state_d;
    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic                 sod_q, sod_d;
    logic                 need_q, need_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 tick_s;
    logic                 wr_s;
    logic                 pending_s;
    logic                 last_data_s;
    logic                 last_stop_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 cell0_s;
    logic [DATA_BITS-1:0] load_data_s;
    logic [N-1:0]         set_pattern_s;

    assign tick_s      = bus.bit_tick;
    assign wr_s        = bus.serout_wr;
    // A write landing on the final stop tick still counts as a pending byte
    assign pending_s   = buf_full_q | wr_s;
    assign last_data_s = (bit_cnt_q == BCW'(DATA_BITS - 1));
    assign last_stop_s = (stop_cnt_q == 2'(STOP_BITS - 1));
    assign load_data_s = wr_s ? bus.serout_data : buf_q;
    assign set_pattern_s = {{STOP_BITS{1'b1}}, load_data_s};

    pokey_shift_chain #(
        .N (N)
    ) u_chain (
        .clk     (clk),
        .reset   (reset),
        .enp_i   (bus.enp),
        .shift_i (shift_s),
        .load_i  (load_s),
        .set_i   (set_pattern_s),
        .d_i     (1'b1),
        .q0_o    (cell0_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (bus.enp) begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) state_d = ST_START;
                else            state_d = ST_IDLE;
            end
            ST_START: begin
                if (tick_s) state_d = ST_DATA;
                else        state_d = ST_START;
            end
            ST_DATA: begin
                if (tick_s && last_data_s) state_d = ST_STOP;
                else                       state_d = ST_DATA;
            end
            ST_STOP: begin
                if (tick_s && last_stop_s) state_d = pending_s ? ST_START : ST_IDLE;
                else                       state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: chain control, serial bit and counters
    always_comb begin
        load_s     = 1'b0;
        shift_s    = 1'b0;
        sod_d      = sod_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    load_s = 1'b1;
                    sod_d  = 1'b0;
                end else begin
                    sod_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    shift_s   = 1'b1;
                    sod_d     = cell0_s;
                    bit_cnt_d = '0;
                end else begin
                    sod_d     = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_s = 1'b1;
                    if (last_data_s) begin
                        sod_d      = 1'b1;
                        stop_cnt_d = 2'd0;
                    end else begin
                        sod_d      = cell0_s;
                        bit_cnt_d  = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    sod_d = sod_q;
                end
            end
            ST_STOP: begin
                if (tick_s && last_stop_s) begin
                    if (pending_s) begin
                        load_s = 1'b1;
                        sod_d  = 1'b0;
                    end else begin
                        sod_d  = 1'b1;
                    end
                end else if (tick_s) begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                    sod_d      = 1'b1;
                end else begin
                    sod_d      = 1'b1;
                end
            end
            default: sod_d = 1'b1;
        endcase
    end

    // Buffer and status next values; a load always consumes any same-cycle write
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (wr_s) begin
            buf_d = bus.serout_data;
        end else begin
            buf_d = buf_q;
        end
        if (load_s) begin
            buf_full_d = 1'b0;
        end else if (wr_s) begin
            buf_full_d = 1'b1;
        end else begin
            buf_full_d = buf_full_q;
        end
        need_d = load_s;
        done_d = (state_d == ST_IDLE) && !buf_full_d;
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 2'd0;
            sod_q      <= 1'b1;
            need_q     <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else if (bus.enp) begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            sod_q      <= sod_d;
            need_q     <= need_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Break overrides the line without disturbing sequencing
    assign bus.sod         = sod_q & ~bus.force_break;
    assign bus.serout_need = need_q;
    assign bus.xmit_done   = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_pokey_serout_ctrl.sv
// Directed bench for pokey_serout_ctrl: table of per-enp-cycle records with
// hand-derived line/IRQ expectations, plus an asynchronous-reset sequence.
module tb_pokey_serout_ctrl;
    import pokey_serout_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pokey_serout_ctrl_if #(.DATA_BITS(8)) bus ();

    pokey_serout_ctrl #(
        .DATA_BITS (8),
        .STOP_BITS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // exp packs {sod, serout_need, xmit_done, busy}
    typedef struct {
        logic       tick;
        logic       wr;
        logic [7:0] data;
        logic       brk;
        int         gap;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic tick, input logic wr, input logic [7:0] data,
                                input logic brk, input int gap, input logic sod,
                                input logic need, input logic done, input logic busy);
        vec_t v;
        v.tick = tick;
        v.wr   = wr;
        v.data = data;
        v.brk  = brk;
        v.gap  = gap;
        v.exp  = {sod, need, done, busy};
        vecs.push_back(v);
    endfunction

    // Eight bit ticks of a frame: wire shows bit i of b after tick i (LSB first)
    function automatic void add_bits(input logic [7:0] b, input logic [7:0] brk_mask,
                                     input int a1, input logic [7:0] d1,
                                     input int a2, input logic [7:0] d2);
        for (int i = 0; i < 8; i++) begin
            add(1'b1, (i == a1) || (i == a2), (i == a2) ? d2 : d1, brk_mask[i], 15,
                b[i] & ~brk_mask[i], 1'b0, 1'b0, 1'b1);
        end
    endfunction

    // One enp cycle with the given inputs, then a disabled cycle full of junk
    task automatic ecyc(input logic tick, input logic wr, input logic [7:0] data, input logic brk);
        bus.enp         = 1'b1;
        bus.bit_tick    = tick;
        bus.serout_wr   = wr;
        bus.serout_data = data;
        bus.force_break = brk;
        @(posedge clk); #1;
        bus.enp         = 1'b0;
        bus.bit_tick    = 1'b1;
        bus.serout_wr   = 1'b1;
        bus.serout_data = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.sod, bus.serout_need, bus.xmit_done, bus.busy};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: sod/need/done/busy got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vecs(input string tag);
        logic [3:0] gexp;
        logic [3:0] act;
        int         bad;
        for (int i = 0; i < vecs.size(); i++) begin
            ecyc(vecs[i].tick, vecs[i].wr, vecs[i].data, vecs[i].brk);
            check($sformatf("%s_v%0d", tag, i), vecs[i].exp);
            if (vecs[i].gap > 0) begin
                gexp = {vecs[i].exp[3], 1'b0, vecs[i].exp[1:0]};
                bad  = 0;
                for (int g = 0; g < vecs[i].gap; g++) begin
                    ecyc(1'b0, 1'b0, 8'h00, vecs[i].brk);
                    act = {bus.sod, bus.serout_need, bus.xmit_done, bus.busy};
                    if (act !== gexp) bad++;
                end
                n_tests++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL %s_v%0d_hold: %0d cycles differed, required %b", tag, i, bad, gexp);
                end
            end
        end
        vecs.delete();
    endtask

    initial begin
        reset           = 1'b1;
        bus.enp         = 1'b0;
        bus.bit_tick    = 1'b0;
        bus.serout_wr   = 1'b0;
        bus.serout_data = 8'h00;
        bus.force_break = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'b1010);
        reset = 1'b0;

        // Idle with ticks present: nothing must start
        add(1'b1, 1'b0, 8'h00, 1'b0, 19, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("idle");

        // Single frame 0xA5
        add(1'b0, 1'b1, 8'hA5, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'hA5, 8'h00, -1, 8'h00, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("a5");

        // Back-to-back 0x3C then 0x81, no mark gap
        add(1'b0, 1'b1, 8'h3C, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'h3C, 8'h00, 1, 8'h81, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'h81, 8'h00, -1, 8'h00, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("b2b");

        // Overwrite while full: 0x11 lost, 0x22 sent
        add(1'b0, 1'b1, 8'h5A, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'h5A, 8'h00, 1, 8'h11, 3, 8'h22);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'h22, 8'h00, -1, 8'h00, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("ovw");

        // Break over data bits 2..4 of 0xFF; timing unchanged
        add(1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'hFF, 8'b0001_1100, -1, 8'h00, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("brk");

        // Frame 0x00 into data bit 4, with 0x77 parked in the buffer
        add(1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            add(1'b1, i == 2, 8'h77, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        run_vecs("pre_rst");

        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 4'b1010);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_release", 4'b1010);

        // Buffer must have been cleared, then a clean 0xFF frame
        add(1'b0, 1'b0, 8'h00, 1'b0, 20, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 15, 1'b0, 1'b1, 1'b0, 1'b1);
        add_bits(8'hFF, 8'h00, -1, 8'h00, -1, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vecs("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
